// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter for the single shared memory port
//
// Purpose: grants the shared memory port to the instruction fetch unit
// (read-only) or the load/store unit (read/write), one transaction at a
// time. LSU has fixed priority; a starvation counter forces an IFU grant
// after STARVE_LIMIT consecutive LSU grants while the IFU was waiting.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ifu_req_*             IFU request (valid/ready, addr)
//   ifu_resp_valid/rdata  IFU response pulse and data
//   lsu_req_*             LSU request (valid/ready, addr, wen, wdata, wmask)
//   lsu_resp_valid/rdata  LSU response pulse and data
//   mem_req_*             request to memory (valid/ready, latched fields)
//   mem_resp_valid/rdata  memory response (read data or write ack)

module mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int         MASK_W = DATA_W / 8;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state, state_nxt;
  logic                owner;          // 0 = IFU, 1 = LSU
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [3:0]          starve_cnt;

  logic force_ifu, grant_lsu, grant_ifu;

  // Grant is only offered in IDLE; a ready implies the matching valid,
  // so a grant is also the handshake.
  always_comb begin
    force_ifu = ifu_req_valid && (starve_cnt == LIMIT);
    grant_lsu = (state == IDLE) && lsu_req_valid && !force_ifu;
    grant_ifu = (state == IDLE) && ifu_req_valid && !grant_lsu;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_lsu || grant_ifu) state_nxt = REQ;
      REQ:     if (mem_req_ready)          state_nxt = RESP;
      RESP:    if (mem_resp_valid)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; memory fields are driven only while the request is presented
  // so the port reads all-zero whenever the arbiter is idle.
  always_comb begin
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;
    mem_req_valid  = (state == REQ);
    mem_addr       = (state == REQ) ? addr_q  : '0;
    mem_wen        = (state == REQ) ? wen_q   : 1'b0;
    mem_wdata      = (state == REQ) ? wdata_q : '0;
    mem_wmask      = (state == REQ) ? wmask_q : '0;
    ifu_resp_valid = (state == RESP) && mem_resp_valid && !owner;
    lsu_resp_valid = (state == RESP) && mem_resp_valid &&  owner;
    ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
  end

  // Request latch and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      starve_cnt <= '0;
    end else if (grant_lsu) begin
      owner   <= 1'b1;
      addr_q  <= lsu_addr;
      wen_q   <= lsu_wen;
      wdata_q <= lsu_wdata;
      wmask_q <= lsu_wmask;
      // Count only LSU wins that actually made the IFU wait.
      if (!ifu_req_valid)       starve_cnt <= '0;
      else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else if (grant_ifu) begin
      owner      <= 1'b0;
      addr_q     <= ifu_addr;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      starve_cnt <= '0;
    end
  end

endmodule
